operand_entry_ctrl: RTL

Parametrised operand-entry and display controller for the calculator datapath. It captures NUM_OPERANDS signed operands from the switch bank on confirm-button edges and hands them to the ALU with a valid/ready handshake. It then latches the ALU result and drives the value and mode flag shown on the seven-segment display. It sits between the debounced board inputs and the ALU/display driver.

---
 rtl/calc_pkg.sv | 14 +
 rtl/rise_edge_detect.sv | 21 ++
 rtl/operand_entry_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared types and default widths for the calculator datapath blocks.
package calc_pkg;

  typedef enum logic [1:0] {
    ENTRY = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    SHOW  = 2'd3
  } entry_state_t;

  localparam int DATA_W_DEF = 6;
  localparam int IN_W_DEF   = 4;

endpackage

// File: rtl/rise_edge_detect.sv
// Single-cycle rising-edge pulse from a level already synchronous to clk.
module rise_edge_detect #(
  parameter logic RESET_LEVEL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_level,
  output logic o_rise
);

  logic r_prev;

  // Resetting the previous level high keeps a button held through reset from firing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_prev <= RESET_LEVEL;
    else       r_prev <= i_level;
  end

  assign o_rise = i_level & ~r_prev;

endmodule

// File: rtl/operand_entry_ctrl.sv
// Operand entry, ALU handshake and display control for the calculator.
// Optional feature: define OPERAND_SIGN_EN to add the sign_in negate input.
module operand_entry_ctrl
  import calc_pkg::*;
#(
  parameter int  DATA_W       = DATA_W_DEF,
  parameter int  IN_W         = IN_W_DEF,
  parameter int  NUM_OPERANDS = 2,
  localparam int IDX_W        = (NUM_OPERANDS > 1) ? $clog2(NUM_OPERANDS) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           confirm,
  input  logic                           mode_btn,
  input  logic [IN_W-1:0]                operand_input,
`ifdef OPERAND_SIGN_EN
  input  logic                           sign_in,
`endif
  input  logic                           ops_ready,
  input  logic [DATA_W-1:0]              result_in,
  input  logic                           result_valid,
  output logic [NUM_OPERANDS*DATA_W-1:0] operands,
  output logic                           ops_valid,
  output logic [DATA_W-1:0]              display_value,
  output logic                           display_mode,
  output logic [IDX_W-1:0]               entry_index,
  output logic                           busy
);

  if (IN_W > DATA_W - 1) begin : g_check_in_w
    $error("operand_entry_ctrl: IN_W must be at most DATA_W-1");
  end
  if (NUM_OPERANDS < 1) begin : g_check_num
    $error("operand_entry_ctrl: NUM_OPERANDS must be at least 1");
  end

  logic                           w_confirm_rise;
  logic                           w_mode_rise;
  logic [DATA_W-1:0]              w_zext;
  logic [DATA_W-1:0]              w_entered;

  entry_state_t                   r_state;
  logic [IDX_W-1:0]               r_idx;
  logic [NUM_OPERANDS*DATA_W-1:0] r_operands;
  logic [DATA_W-1:0]              r_result;
  logic [DATA_W-1:0]              r_display;
  logic                           r_mode;
  logic                           r_ops_valid;
  logic                           r_busy;

  rise_edge_detect #(.RESET_LEVEL(1'b1)) u_confirm_edge (
    .clk     (clk),
    .reset   (reset),
    .i_level (confirm),
    .o_rise  (w_confirm_rise)
  );

  rise_edge_detect #(.RESET_LEVEL(1'b1)) u_mode_edge (
    .clk     (clk),
    .reset   (reset),
    .i_level (mode_btn),
    .o_rise  (w_mode_rise)
  );

  assign w_zext = DATA_W'(operand_input);

`ifdef OPERAND_SIGN_EN
  assign w_entered = sign_in ? (-w_zext) : w_zext;
`else
  assign w_entered = w_zext;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ENTRY;
      r_idx       <= '0;
      r_operands  <= '0;
      r_result    <= '0;
      r_display   <= '0;
      r_mode      <= 1'b0;
      r_ops_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      if (w_mode_rise) r_mode <= ~r_mode;

      case (r_state)
        ENTRY: begin
          // The preview register also ends up holding the last captured operand for ISSUE.
          r_display <= w_entered;
          if (w_confirm_rise) begin
            r_operands[r_idx*DATA_W +: DATA_W] <= w_entered;
            if (r_idx == IDX_W'(NUM_OPERANDS - 1)) begin
              r_state     <= ISSUE;
              r_ops_valid <= 1'b1;
              r_busy      <= 1'b1;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end
        ISSUE: begin
          if (r_ops_valid && ops_ready) begin
            r_state     <= WAIT;
            r_ops_valid <= 1'b0;
          end
        end
        WAIT: begin
          if (result_valid) begin
            r_result  <= result_in;
            r_display <= result_in;
            r_state   <= SHOW;
            r_busy    <= 1'b0;
          end
        end
        SHOW: begin
          r_display <= r_result;
          if (w_confirm_rise) begin
            r_idx   <= '0;
            r_state <= ENTRY;
          end
        end
        default: r_state <= ENTRY;
      endcase
    end
  end

  assign operands      = r_operands;
  assign ops_valid     = r_ops_valid;
  assign display_value = r_display;
  assign display_mode  = r_mode;
  assign entry_index   = r_idx;
  assign busy          = r_busy;

endmodule
